// File: rtl/apple_vga_scandoubler_if.sv
// Dot-stream input and mono VGA output bundle for apple_vga_scandoubler.
// master = video generator / display side, slave = the scandoubler itself.
interface apple_vga_scandoubler_if;
    logic dot_en;
    logic dot;
    logic src_line_start;
    logic src_frame_start;
    logic vga_pix;
    logic vga_hs;
    logic vga_vs;
    logic vga_de;
    logic ovf;

    modport master (
        output dot_en, dot, src_line_start, src_frame_start,
        input  vga_pix, vga_hs, vga_vs, vga_de, ovf
    );

    modport slave (
        input  dot_en, dot, src_line_start, src_frame_start,
        output vga_pix, vga_hs, vga_vs, vga_de, ovf
    );
endinterface

// File: rtl/apple_vga_scandoubler.sv
// Ping-pong line buffers fed by the mono dot stream, replayed at 640x480@60 on a
// 25 MHz pixel enable derived from CLOCK_50; each source line is shown on two VGA lines.
module apple_vga_scandoubler #(
    parameter int SRC_W = 560,
    parameter int X_OFF = 40,
    parameter int Y_OFF = 48
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    apple_vga_scandoubler_if.slave  vid_io
);

    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [9:0] HS_BEG  = 10'd656;
    localparam logic [9:0] HS_END  = 10'd751;
    localparam logic [9:0] VS_BEG  = 10'd490;
    localparam logic [9:0] VS_END  = 10'd491;
    localparam logic [9:0] H_ACT   = 10'd640;
    localparam logic [9:0] V_ACT   = 10'd480;
    localparam logic [9:0] SRC_W_L = 10'(SRC_W);
    localparam logic [9:0] X_LO    = 10'(X_OFF);
    localparam logic [9:0] X_HI    = 10'(X_OFF + SRC_W);
    localparam logic [9:0] Y_LO    = 10'(Y_OFF);
    localparam logic [9:0] Y_HI    = 10'(Y_OFF + 384);
    localparam logic [9:0] Y_LOCK  = 10'(Y_OFF - 2);

    // write side state
    logic             wr_sel_q;
    logic [9:0]       wr_ptr_q;
    logic [9:0]       len_q [2];
    logic             ovf_q;
    logic [SRC_W-1:0] buf_q [2];

    // VGA side state
    logic       pe_q;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       lock_pend_q, lock_pend_d;
    logic       pix_q, hs_q, vs_q, de_q;

    logic       wsel_eff;
    logic [9:0] wptr_eff;
    logic       wr_fire;

    // A line start in the same cycle as a dot swaps first, so the dot lands at index 0.
    always_comb begin
        wsel_eff = vid_io.src_line_start ? ~wr_sel_q : wr_sel_q;
        wptr_eff = vid_io.src_line_start ? 10'd0 : wr_ptr_q;
        wr_fire  = vid_io.dot_en && (wptr_eff < SRC_W_L);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wr_sel_q <= 1'b0;
            wr_ptr_q <= 10'd0;
            len_q[0] <= 10'd0;
            len_q[1] <= 10'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (vid_io.src_line_start) begin
                len_q[wr_sel_q] <= wr_ptr_q;
                wr_sel_q        <= ~wr_sel_q;
            end
            wr_ptr_q <= wr_fire ? wptr_eff + 10'd1 : wptr_eff;
            if (vid_io.dot_en && !wr_fire) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_fire) begin
            buf_q[wsel_eff][wptr_eff] <= vid_io.dot;
        end
    end

    logic       rd_sel;
    logic       in_win;
    logic [9:0] x_idx;
    logic       pix_d;

    // Read side is combinational on the current counters; the length mask hides stale data.
    always_comb begin
        rd_sel = ~wr_sel_q;
        in_win = (hcount_q >= X_LO) && (hcount_q < X_HI) &&
                 (vcount_q >= Y_LO) && (vcount_q < Y_HI);
        x_idx  = in_win ? (hcount_q - X_LO) : 10'd0;
        pix_d  = in_win && (x_idx < len_q[rd_sel]) && buf_q[rd_sel][x_idx];
    end

    always_comb begin
        hcount_d    = (hcount_q == H_LAST) ? 10'd0 : hcount_q + 10'd1;
        vcount_d    = vcount_q;
        lock_pend_d = lock_pend_q;
        if (hcount_q == H_LAST) begin
            if (lock_pend_q) begin
                vcount_d = Y_LOCK;
            end else if (vcount_q == V_LAST) begin
                vcount_d = 10'd0;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end
        if (pe_q && (hcount_q == H_LAST)) begin
            lock_pend_d = 1'b0;
        end
        if (vid_io.src_frame_start) begin
            lock_pend_d = 1'b1;
        end
    end

    // Outputs are registered from the pre-increment counters: one pe of latency.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pe_q        <= 1'b0;
            hcount_q    <= 10'd0;
            vcount_q    <= 10'd0;
            lock_pend_q <= 1'b0;
            pix_q       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
        end else begin
            pe_q        <= ~pe_q;
            lock_pend_q <= lock_pend_d;
            if (pe_q) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                pix_q    <= pix_d;
                hs_q     <= !((hcount_q >= HS_BEG) && (hcount_q <= HS_END));
                vs_q     <= !((vcount_q >= VS_BEG) && (vcount_q <= VS_END));
                de_q     <= (hcount_q < H_ACT) && (vcount_q < V_ACT);
            end
        end
    end

    assign vid_io.vga_pix = pix_q;
    assign vid_io.vga_hs  = hs_q;
    assign vid_io.vga_vs  = vs_q;
    assign vid_io.vga_de  = de_q;
    assign vid_io.ovf     = ovf_q;

endmodule

// File: doc/apple_vga_scandoubler.md
# apple_vga_scandoubler

Downstream stage of the video generator. It takes the serial mono dot stream (560 dots per active line, 192 lines), buffers each source line in ping-pong line RAMs, and replays each line twice at 640x480@60 VGA timing. The 560x384 image is centred with black borders. It runs entirely on the 50 MHz system clock using clock enables.

## Interface
Parameters:
- SRC_W, 560: dots per source line stored.
- X_OFF, 40: first VGA column of the image window.
- Y_OFF, 48: first VGA row of the image window.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  reset, synchronous and active-high.
- dot_en  in  1  one-cycle strobe; `dot` is valid this cycle.
- dot  in  1  mono pixel from the video generator.
- src_line_start  in  1  one-cycle pulse; a new active source line begins.
- src_frame_start  in  1  one-cycle pulse, coincident with `src_line_start` of source line 0.
- vga_pix  out  1  VGA mono pixel.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_de  out  1  display enable (active 640x480 region).
- ovf  out  1  sticky flag: a dot arrived after the buffer was full.

## Operation
- Two line buffers, each SRC_W x 1 bit, plus a length register per buffer (10 bits, range 0..560). `wr_sel` selects the write buffer; the read buffer is always `~wr_sel`.
- Write side:
  - On `src_line_start`: latch `len[wr_sel] <= wr_ptr`, toggle `wr_sel`, set `wr_ptr <= 0`.
  - On `dot_en` with `wr_ptr < SRC_W`: write `dot` to `buf[wr_sel][wr_ptr]`, then `wr_ptr++`.
  - On `dot_en` with `wr_ptr == SRC_W`: drop the dot and set `ovf <= 1`.
  - `src_line_start` and `dot_en` in the same cycle: the swap happens first, the dot goes to index 0 of the new buffer, and `wr_ptr = 1`.
- Pixel enable `pe` toggles every clock; `pe = 1` first on cycle 1 after reset is released. All VGA state advances only on `pe` cycles.
- Counters:
  - `hcount` runs 0..799 and wraps.
  - `vcount` increments on each `hcount` wrap and runs 0..524.
- Sync and enable:
  - `vga_hs` is low for `hcount` 656..751.
  - `vga_vs` is low for `vcount` 490..491.
  - `vga_de = (hcount < 640) && (vcount < 480)`.
- Image window: `hcount` in [X_OFF, X_OFF+SRC_W) and `vcount` in [Y_OFF, Y_OFF+384).
  - `x = hcount - X_OFF`.
  - `vga_pix = buf[~wr_sel][x]` if in the window and `x < len[~wr_sel]`; otherwise 0.
- Each source line is shown on both VGA lines that fall inside one source-line period. No vertical index is kept; only the read buffer is used.
- Genlock: `src_frame_start` sets `lock_pend`. At the next `hcount` wrap with `lock_pend = 1`, `vcount <= Y_OFF-2` instead of incrementing, and `lock_pend` clears.
- A buffer swap in the middle of a VGA line is allowed; the pixels on that line switch to the new buffer immediately. This tearing is accepted.
- `ovf` clears only on RESET.

## Timing
- Reset values, one cycle after RESET is sampled high:
  - `hcount = 0`, `vcount = 0`, `pe = 0`.
  - `wr_sel = 0`, `wr_ptr = 0`, `len[0] = len[1] = 0`, `lock_pend = 0`, `ovf = 0`.
  - `vga_hs = 1`, `vga_vs = 1`, `vga_de = 0`, `vga_pix = 0`.
  - Buffer contents are not reset; `len = 0` masks them.
- RESET in the middle of a frame or line aborts everything and returns to the reset values on the next cycle. A pending genlock is lost.
- Output latency: the VGA outputs are registered on `pe` and reflect the counter values from before that same `pe` increment. This is a one-`pe` (2-clock) pipeline.
- The buffer read is combinational or uses a one-cycle RAM read. In either case the output alignment above must hold. A RAM read is issued on the non-`pe` cycle.
- Line period is 1600 clocks with `vga_hs` low for 192 clocks. Frame period is 840000 clocks with `vga_vs` low for 3200 clocks.
- Write-side latency: a dot written at cycle t is visible to the reader only after the next `src_line_start`.

## Test plan
- Reset and free-run: hold RESET for 6 cycles, then release.
  - All outputs equal the reset values above.
  - First `vga_hs` fall at clock 1313 ±1 after release; `vga_hs` period is 1600 clocks, low width 192.
  - `vga_vs` low for 3200 clocks every 840000.
- Full line: send 560 dots alternating 1,0, then `src_line_start`, then `src_frame_start`.
  - On both window rows of the next source period: `vga_pix` is 1 at x=40, 0 at x=41, 0 at x=599.
  - `vga_pix = 0` at x=600 and x=39.
- Short line: send 100 ones, then `src_line_start`.
  - `vga_pix = 1` for columns 40..139 and 0 for columns 140..599.
- Overflow: send 600 ones in one line.
  - `ovf = 1` from the 561st dot onward; columns 40..599 are all 1.
  - `ovf` stays 1 across later lines until RESET.
- Genlock: pulse `src_frame_start` while `vcount = 200`.
  - After the next `hcount` wrap, `vcount = 46`; the next `vga_vs` fall comes 444 lines later.
- Simultaneous events: assert `src_line_start` and `dot_en` (`dot = 1`) in the same cycle, followed by 559 zeros, then `src_line_start`.
  - Column 40 shows 1; columns 41..599 show 0.
  - `len` of that buffer is 560.
